arc4_core: RTL and testbench
============================

Name: arc4_core

Overview:
- ARC4 (RC4) decryption engine with a 24-bit key.
- Reads a length-prefixed ciphertext from an external CT memory and writes the length-prefixed plaintext to an external PT memory.
- Owns a private 256x8 state array S.
- Used by higher-level key-search logic through an en/rdy handshake.

Parameters:
- None. Key width is fixed at 24 bits (3 bytes), S size at 256, and memory address/data width at 8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  start request; accepted only while rdy=1.
- rdy  output  1  1 = idle and able to accept en.
- key  input  24  key; key[23:16] is key byte 0, key[15:8] is byte 1, key[7:0] is byte 2. Sampled when en is accepted.
- ct_addr  output  8  CT memory read address.
- ct_rddata  input  8  CT read data, valid one cycle after ct_addr.
- pt_addr  output  8  PT memory address.
- pt_rddata  input  8  PT read data; unused, present for interface compatibility.
- pt_wrdata  output  8  PT write data.
- pt_wren  output  1  PT write strobe; one write per cycle in which it is high.

Behaviour:
- Reset: while rst_n=0 at a clock edge, go to IDLE.
  - Outputs: rdy=1, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0.
  - Reset mid-operation aborts immediately; PT contents already written are left as is.
- Handshake:
  - In IDLE, rdy=1. en=1 at a clock edge latches key, drops rdy on the next cycle and starts INIT.
  - en is ignored while rdy=0.
  - rdy returns to 1 when the last PT write completes.
  - A new en may be accepted in the same cycle rdy rises.
- Memory timing: CT memory and S are synchronous-read with one-cycle latency. Every read waits one cycle before its data is used.
- INIT: for i=0..255, S[i]=i; one write per cycle, 256 cycles.
- KSA: j=0; for i=0..255:
  - j = (j + S[i] + keybyte[i mod 3]) mod 256.
  - Swap S[i] and S[j]. A read-modify-write is required when i==j; the result must leave S[i] unchanged.
- PRGA:
  - Read L=ct[0]; write pt[0]=L. Set i=j=0.
  - For k=1..L:
    - i=(i+1) mod 256.
    - j=(j+S[i]) mod 256.
    - Swap S[i] and S[j].
    - pad = S[(S[i]+S[j]) mod 256], using the post-swap values.
    - pt[k] = pad XOR ct[k].
  - L=0 produces only the pt[0] write. L=255 writes pt[1..255]; the address does not wrap.
- Arithmetic: all index sums are 8-bit and wrap modulo 256; keybyte index is i mod 3.
- Ordering: pt writes occur in ascending address order, and pt_wren is a single-cycle pulse per byte.
- Latency budget:
  - INIT is 256 cycles.
  - KSA is at most 6 cycles per i.
  - PRGA is at most 10 cycles per byte, plus at most 4 cycles of fixed overhead.
- State machine, top level: IDLE -> INIT -> KSA -> PRGA_LEN -> PRGA_LOOP -> DONE -> IDLE.
  - Sub-states are read-issue, read-wait, compute and write, as needed for 1-cycle memory latency.
  - DONE asserts rdy; DONE and IDLE may be merged.

Decomposition:
- Package arc4_pkg:
  - State enum (IDLE, INIT, KSA_*, PRGA_*, DONE).
  - Constants S_SIZE=256 and KEY_BYTES=3.
  - Byte typedef.
- Sub-module arc4_smem: 256x8 single-port RAM with clk, addr[7:0], wrdata[7:0], wren, rddata[7:0] and registered read. Instantiated once inside arc4_core as S.
- No separate init/ksa/prga modules; one FSM sequences all phases.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> rdy=1, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0. Holding en=1 during reset starts nothing.
- Standard vector:
  - Stimulus: key=24'h4B6579 ("Key"); CT = {9, BB,F3,16,E8,D9,40,AF,0A,D3}; pulse en.
  - Required: PT = {09, 50,6C,61,69,6E,74,65,78,74} ("Plaintext"); exactly 10 pt_wren pulses at addresses 0..9; rdy returns to 1.
- Zero-length message: CT[0]=0, any key -> single write pt[0]=00, then rdy=1. S loading (INIT+KSA) still fully executes.
- Busy-ignore and back-to-back:
  - While running the standard vector, toggle en and change key -> output unchanged.
  - Then rerun with key=24'h000000 immediately after rdy rises -> PT bytes equal the software RC4 reference for that key.
- Reset mid-operation:
  - Assert rst_n=0 for one cycle during KSA -> rdy=1 next cycle and no further pt_wren.
  - A following en with the standard vector -> correct "Plaintext" output, showing no state leaks between runs.
- Max length: CT[0]=255 with random bytes -> 256 writes with no address wrap, matching the software model byte for byte.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decryption core.
//   state_t  : top-level sequencer states (INIT, KSA and PRGA sub-states)
//   byte_t   : 8-bit data/address type used by S, CT and PT memories
//   key_byte : selects key byte 0..2 from the packed 24-bit key
package arc4_pkg;

    localparam int unsigned S_SIZE    = 256;
    localparam int unsigned KEY_BYTES = 3;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned KEY_W     = KEY_BYTES * BYTE_W;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        KSA_RD_I,
        KSA_RD_J,
        KSA_WR_I,
        KSA_WR_J,
        PRGA_LEN_RD,
        PRGA_LEN_WAIT,
        PRGA_LEN,
        PRGA_RD_I,
        PRGA_RD_J,
        PRGA_WR_I,
        PRGA_WR_J,
        PRGA_RD_PAD,
        PRGA_OUT,
        DONE
    } state_t;

    // Key byte 0 lives in the most significant byte.
    function automatic byte_t key_byte(input logic [KEY_W-1:0] key, input logic [1:0] idx);
        byte_t kb;
        case (idx)
            2'd0:    kb = key[23:16];
            2'd1:    kb = key[15:8];
            default: kb = key[7:0];
        endcase
        return kb;
    endfunction

endpackage

// File: rtl/arc4_if.sv
// Handshake and memory-bus bundle of the ARC4 core.
//   en/rdy/key          : start handshake and key
//   ct_addr/ct_rddata   : ciphertext memory read port
//   pt_addr/pt_wrdata/pt_wren/pt_rddata : plaintext memory port
// slave is the core side, master is the requester/memory side.
interface arc4_if;
    import arc4_pkg::*;

    logic             en;
    logic             rdy;
    logic [KEY_W-1:0] key;
    byte_t            ct_addr;
    byte_t            ct_rddata;
    byte_t            pt_addr;
    byte_t            pt_rddata;
    byte_t            pt_wrdata;
    logic             pt_wren;

    modport master (
        output en, key, ct_rddata, pt_rddata,
        input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    modport slave (
        input  en, key, ct_rddata, pt_rddata,
        output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

endinterface

// File: rtl/arc4_smem.sv
// 256x8 single-port state RAM with registered (read-first) output.
//   clk    : clock
//   addr   : read/write address
//   wrdata : write data, stored when wren=1
//   rddata : mem[addr] from the previous cycle
module arc4_smem
    import arc4_pkg::*;
(
    input  logic  clk,
    input  byte_t addr,
    input  byte_t wrdata,
    input  logic  wren,
    output byte_t rddata
);

    byte_t mem [S_SIZE];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

endmodule

// File: rtl/arc4_core.sv
// ARC4 decryption engine with a 24-bit key.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : en/rdy/key handshake, CT read port, PT write port
// Runs INIT, KSA and PRGA in one sequencer over a private S RAM and writes
// the length-prefixed plaintext in ascending address order.
module arc4_core
    import arc4_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    arc4_if.slave bus
);

    state_t           state_q, state_n;
    byte_t            i_q, i_n, j_q, j_n, k_q, k_n, len_q, len_n;
    byte_t            si_q, si_n, sj_q, sj_n;
    logic [1:0]       kidx_q, kidx_n;
    logic [KEY_W-1:0] key_q, key_n;
    logic             rdy_q, rdy_n, pt_wren_q, pt_wren_n;
    byte_t            ct_addr_q, ct_addr_n, pt_addr_q, pt_addr_n, pt_wrdata_q, pt_wrdata_n;

    byte_t            s_addr_c, s_wrdata_c, s_rddata;
    logic             s_wren_c;
    byte_t            ksa_j_c, prga_j_c;
    logic             unused_pt_rddata_c;

    arc4_smem u_s (
        .clk    (clk),
        .addr   (s_addr_c),
        .wrdata (s_wrdata_c),
        .wren   (s_wren_c),
        .rddata (s_rddata)
    );

    // s_rddata carries S[i] in the *_RD_J states.
    assign ksa_j_c  = j_q + s_rddata + key_byte(key_q, kidx_q);
    assign prga_j_c = j_q + s_rddata;
    assign unused_pt_rddata_c = ^bus.pt_rddata;

    assign bus.rdy       = rdy_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.pt_wrdata = pt_wrdata_q;
    assign bus.pt_wren   = pt_wren_q;

    // Next-state, datapath and S port control.
    always_comb begin
        state_n     = state_q;
        i_n         = i_q;
        j_n         = j_q;
        k_n         = k_q;
        len_n       = len_q;
        si_n        = si_q;
        sj_n        = sj_q;
        kidx_n      = kidx_q;
        key_n       = key_q;
        rdy_n       = rdy_q;
        ct_addr_n   = ct_addr_q;
        pt_addr_n   = pt_addr_q;
        pt_wrdata_n = pt_wrdata_q;
        pt_wren_n   = 1'b0;
        s_addr_c    = i_q;
        s_wrdata_c  = si_q;
        s_wren_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    key_n   = bus.key;
                    i_n     = 8'd0;
                    rdy_n   = 1'b0;
                    state_n = INIT;
                end
            end
            INIT: begin
                s_wrdata_c = i_q;
                s_wren_c   = 1'b1;
                i_n        = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_n     = 8'd0;
                    kidx_n  = 2'd0;
                    state_n = KSA_RD_I;
                end
            end
            KSA_RD_I: state_n = KSA_RD_J;
            KSA_RD_J: begin
                si_n     = s_rddata;
                j_n      = ksa_j_c;
                s_addr_c = ksa_j_c;
                state_n  = KSA_WR_I;
            end
            // S[i] <= S[j]; then S[j] <= old S[i]. Leaves S[i] intact when i == j.
            KSA_WR_I: begin
                s_wrdata_c = s_rddata;
                s_wren_c   = 1'b1;
                state_n    = KSA_WR_J;
            end
            KSA_WR_J: begin
                s_addr_c = j_q;
                s_wren_c = 1'b1;
                i_n      = i_q + 8'd1;
                kidx_n   = (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx_q + 2'd1;
                state_n  = (i_q == 8'hFF) ? PRGA_LEN_RD : KSA_RD_I;
            end
            PRGA_LEN_RD: begin
                ct_addr_n = 8'd0;
                state_n   = PRGA_LEN_WAIT;
            end
            PRGA_LEN_WAIT: state_n = PRGA_LEN;
            PRGA_LEN: begin
                len_n       = bus.ct_rddata;
                pt_addr_n   = 8'd0;
                pt_wrdata_n = bus.ct_rddata;
                pt_wren_n   = 1'b1;
                i_n         = 8'd1;
                j_n         = 8'd0;
                k_n         = 8'd1;
                ct_addr_n   = 8'd1;
                state_n     = (bus.ct_rddata == 8'd0) ? DONE : PRGA_RD_I;
            end
            PRGA_RD_I: state_n = PRGA_RD_J;
            PRGA_RD_J: begin
                si_n     = s_rddata;
                j_n      = prga_j_c;
                s_addr_c = prga_j_c;
                state_n  = PRGA_WR_I;
            end
            PRGA_WR_I: begin
                sj_n       = s_rddata;
                s_wrdata_c = s_rddata;
                s_wren_c   = 1'b1;
                state_n    = PRGA_WR_J;
            end
            PRGA_WR_J: begin
                s_addr_c = j_q;
                s_wren_c = 1'b1;
                state_n  = PRGA_RD_PAD;
            end
            // Post-swap S[i]+S[j] equals the pre-swap sum si+sj.
            PRGA_RD_PAD: begin
                s_addr_c = si_q + sj_q;
                state_n  = PRGA_OUT;
            end
            // ct_addr has held k since PRGA_RD_I, so ct_rddata is ct[k].
            PRGA_OUT: begin
                pt_addr_n   = k_q;
                pt_wrdata_n = s_rddata ^ bus.ct_rddata;
                pt_wren_n   = 1'b1;
                if (k_q == len_q) begin
                    state_n = DONE;
                end else begin
                    k_n       = k_q + 8'd1;
                    i_n       = i_q + 8'd1;
                    ct_addr_n = k_q + 8'd1;
                    state_n   = PRGA_RD_I;
                end
            end
            DONE: begin
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            kidx_q      <= 2'd0;
            key_q       <= '0;
            rdy_q       <= 1'b1;
            ct_addr_q   <= 8'd0;
            pt_addr_q   <= 8'd0;
            pt_wrdata_q <= 8'd0;
            pt_wren_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            i_q         <= i_n;
            j_q         <= j_n;
            k_q         <= k_n;
            len_q       <= len_n;
            si_q        <= si_n;
            sj_q        <= sj_n;
            kidx_q      <= kidx_n;
            key_q       <= key_n;
            rdy_q       <= rdy_n;
            ct_addr_q   <= ct_addr_n;
            pt_addr_q   <= pt_addr_n;
            pt_wrdata_q <= pt_wrdata_n;
            pt_wren_q   <= pt_wren_n;
        end
    end

endmodule

// File: tb/tb_arc4_core.sv
// Self-checking bench for arc4_core: CT/PT memory models, a software RC4
// reference and directed runs (reset, standard vector, busy-ignore,
// back-to-back, zero length, mid-run reset, maximum length).
module tb_arc4_core;
    import arc4_pkg::*;

    localparam int MAX_CYC = 6000;
    localparam logic [23:0] STD_KEY = 24'h4B6579;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arc4_if bus();

    arc4_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    byte_t ct_mem   [256];
    byte_t pt_mem   [256];
    int    wr_stamp [256];
    byte_t exp_mem  [256];
    int    wr_count = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    byte_t std_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    byte_t std_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

    assign bus.pt_rddata = 8'h00;

    // Synchronous-read CT memory.
    always @(posedge clk) bus.ct_rddata <= ct_mem[bus.ct_addr];

    // PT memory; each write is stamped with a global sequence number.
    always @(posedge clk) begin
        if (bus.pt_wren) begin
            pt_mem[bus.pt_addr]   = bus.pt_wrdata;
            wr_stamp[bus.pt_addr] = wr_count;
            wr_count              = wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_std();
        for (int n = 0; n < 10; n++) ct_mem[n] = std_ct[n];
    endtask

    task automatic expect_std();
        for (int n = 0; n < 10; n++) exp_mem[n] = std_pt[n];
    endtask

    // Software RC4 over ct_mem into exp_mem.
    task automatic model_run(input logic [23:0] k);
        byte_t s [256];
        byte_t kb [3];
        byte_t i, j, t, idx;
        int    len;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j    = j + s[n] + kb[n % 3];
            t    = s[n];
            s[n] = s[j];
            s[j] = t;
        end
        len        = int'(ct_mem[0]);
        exp_mem[0] = ct_mem[0];
        i = 8'd0;
        j = 8'd0;
        for (int n = 1; n <= len; n++) begin
            i          = i + 8'd1;
            j          = j + s[i];
            t          = s[i];
            s[i]       = s[j];
            s[j]       = t;
            idx        = s[i] + s[j];
            exp_mem[n] = s[idx] ^ ct_mem[n];
        end
    endtask

    // Called at a negedge while rdy=1; returns at the negedge after acceptance.
    task automatic start(input logic [23:0] k);
        bus.key = k;
        bus.en  = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rdy(input string tag, output int cycles);
        cycles = 0;
        while (!bus.rdy && cycles < MAX_CYC) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, " rdy"}, 32'(bus.rdy), 32'd1);
    endtask

    task automatic check_pt(input string tag, input int base);
        int len;
        int bad;
        len = int'(exp_mem[0]);
        bad = 0;
        for (int n = 0; n <= len; n++) begin
            check($sformatf("%s pt[%0d]", tag, n), 32'(pt_mem[n]), 32'(exp_mem[n]));
            if (wr_stamp[n] != base + n) bad++;
        end
        check({tag, " write count"}, 32'(wr_count - base), 32'(len + 1));
        check({tag, " write order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int base;
        int cyc;

        bus.en  = 1'b1;
        bus.key = STD_KEY;
        for (int n = 0; n < 256; n++) ct_mem[n] = 8'h00;
        load_std();

        // Reset held 2 cycles with en=1.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rdy",       32'(bus.rdy),       32'd1);
        check("reset pt_wren",   32'(bus.pt_wren),   32'd0);
        check("reset ct_addr",   32'(bus.ct_addr),   32'd0);
        check("reset pt_addr",   32'(bus.pt_addr),   32'd0);
        check("reset pt_wrdata", 32'(bus.pt_wrdata), 32'd0);
        rst_n  = 1'b1;
        bus.en = 1'b0;
        repeat (4) @(negedge clk);
        check("post-reset idle rdy", 32'(bus.rdy), 32'd1);
        check("post-reset no writes", 32'(wr_count), 32'd0);

        // Standard vector with en/key toggled while busy.
        base = wr_count;
        start(STD_KEY);
        check("busy rdy low", 32'(bus.rdy), 32'd0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.en  = 1'($urandom_range(0, 1));
            bus.key = 24'($urandom);
        end
        bus.en = 1'b0;
        wait_rdy("std", cyc);
        expect_std();
        check_pt("std", base);

        // Back-to-back run with key 0, started in the first rdy cycle.
        model_run(24'h000000);
        base = wr_count;
        start(24'h000000);
        wait_rdy("key0", cyc);
        check_pt("key0", base);

        // Zero-length message.
        ct_mem[0] = 8'h00;
        base = wr_count;
        start(24'hABCDEF);
        wait_rdy("zero", cyc);
        check("zero S load time", 32'(cyc >= 512), 32'd1);
        exp_mem[0] = 8'h00;
        check_pt("zero", base);

        // Reset during KSA, then a clean standard run.
        load_std();
        base = wr_count;
        start(STD_KEY);
        repeat (400) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset rdy", 32'(bus.rdy), 32'd1);
        check("midreset pt_wren", 32'(bus.pt_wren), 32'd0);
        repeat (40) @(negedge clk);
        check("midreset no writes", 32'(wr_count - base), 32'd0);
        base = wr_count;
        start(STD_KEY);
        wait_rdy("after reset", cyc);
        expect_std();
        check_pt("after reset", base);

        // Maximum length with random ciphertext.
        ct_mem[0] = 8'hFF;
        for (int n = 1; n < 256; n++) ct_mem[n] = 8'($urandom);
        model_run(24'h1A2B3C);
        base = wr_count;
        start(24'h1A2B3C);
        wait_rdy("maxlen", cyc);
        check_pt("maxlen", base);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
